// File: rtl/uart_pkg.sv
// uart_pkg: parity encodings, state types and default bit period shared by the UART files
package uart_pkg;
   localparam int PARITY_NONE = 0;
   localparam int PARITY_ODD = 1;
   localparam int PARITY_EVEN = 2;
   localparam int DEFAULT_CLKS_PER_BIT = 27_000_000 / 115_200;
   typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} txState_t;
   typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP, RX_WAIT_IDLE} rxState_t;
endpackage

// File: rtl/uart_if.sv
// uart_if: byte-level valid/ready ports between the UART core and its client
interface uart_if #(parameter int DATA_BITS = 8);
   logic [DATA_BITS-1:0] tx_data;
   logic tx_valid;
   logic tx_ready;
   logic [DATA_BITS-1:0] rx_data;
   logic rx_frame_err;
   logic rx_parity_err;
   logic rx_valid;
   logic rx_ready;
   logic rx_overrun;
   modport master(
      output tx_data, tx_valid, rx_ready,
      input tx_ready, rx_data, rx_frame_err, rx_parity_err, rx_valid, rx_overrun
   );
   modport slave(
      input tx_data, tx_valid, rx_ready,
      output tx_ready, rx_data, rx_frame_err, rx_parity_err, rx_valid, rx_overrun
   );
endinterface

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: synchronous first-word-fallthrough FIFO; head reads as zero while empty
module uart_rx_fifo #(
   parameter int WIDTH = 10,
   parameter int DEPTH = 4,
   localparam int AW = $clog2(DEPTH)
) (
   input logic clk,
   input logic rst,
   input logic push,
   input logic pop,
   input logic [WIDTH-1:0] wrData,
   output logic [WIDTH-1:0] rdData,
   output logic full,
   output logic empty,
   output logic [AW:0] count
);
   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0] wrPtr;
   logic [AW-1:0] rdPtr;
   logic doPush;
   logic doPop;
   assign empty = count == '0;
   assign full = count == (AW+1)'(DEPTH);
   assign doPop = pop && !empty;
   // a pop in the same cycle frees the slot a push into a full FIFO needs
   assign doPush = push && (!full || doPop);
   assign rdData = empty ? '0 : mem[rdPtr];
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         wrPtr <= '0;
         rdPtr <= '0;
         count <= '0;
      end else begin
         wrPtr <= wrPtr + AW'(doPush);
         rdPtr <= rdPtr + AW'(doPop);
         count <= count + (AW+1)'(doPush) - (AW+1)'(doPop);
      end
   always_ff @(posedge clk)
      if (doPush) mem[wrPtr] <= wrData;
endmodule

// File: rtl/uart_core.sv
// uart_core: full-duplex UART with configurable framing, valid/ready byte ports
// and a small receive FIFO carrying per-byte framing/parity error flags.
module uart_core import uart_pkg::*; #(
   parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
   parameter int DATA_BITS = 8,
   parameter int PARITY = PARITY_NONE,
   parameter int STOP_BITS = 1,
   parameter int RX_FIFO_DEPTH = 4
) (
   input logic clk,
   input logic rst,
   uart_if.slave bus,
   input logic uart_rx,
   output logic uart_tx
);
   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam int BW = $clog2(DATA_BITS + 1);
   localparam int FW = DATA_BITS + 2;
   localparam int AW = $clog2(RX_FIFO_DEPTH);
   localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2);
   localparam logic ODD = PARITY == PARITY_ODD;
   localparam logic HAS_PAR = PARITY != PARITY_NONE;
   txState_t txState;
   logic [CW-1:0] txCnt;
   logic [BW-1:0] txBit;
   logic [DATA_BITS-1:0] txShift;
   logic txPar;
   assign bus.tx_ready = txState == TX_IDLE;
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         txState <= TX_IDLE;
         uart_tx <= 1'b1;
         txCnt <= '0;
         txBit <= '0;
         txShift <= '0;
         txPar <= 1'b0;
      end else if (txState == TX_IDLE) begin
         if (bus.tx_valid) begin
            txState <= TX_START;
            uart_tx <= 1'b0;
            txCnt <= '0;
            txBit <= '0;
            txShift <= bus.tx_data;
            txPar <= ^bus.tx_data ^ ODD;
         end
      end else if (txCnt != LAST) txCnt <= txCnt + 1'b1;
      else begin
         txCnt <= '0;
         case (txState)
            TX_START: begin
               uart_tx <= txShift[0];
               txShift <= txShift >> 1;
               txState <= TX_DATA;
            end
            TX_DATA:
               if (txBit == BW'(DATA_BITS - 1)) begin
                  txBit <= '0;
                  uart_tx <= HAS_PAR ? txPar : 1'b1;
                  txState <= HAS_PAR ? TX_PARITY : TX_STOP;
               end else begin
                  txBit <= txBit + 1'b1;
                  uart_tx <= txShift[0];
                  txShift <= txShift >> 1;
               end
            TX_PARITY: begin
               uart_tx <= 1'b1;
               txState <= TX_STOP;
            end
            TX_STOP:
               if (txBit == BW'(STOP_BITS - 1)) begin
                  txBit <= '0;
                  txState <= TX_IDLE;
               end else txBit <= txBit + 1'b1;
            default: txState <= TX_IDLE;
         endcase
      end
   logic [1:0] rxSync;
   logic rxS;
   always_ff @(posedge clk or posedge rst)
      if (rst) rxSync <= 2'b11;
      else rxSync <= {rxSync[0], uart_rx};
   assign rxS = rxSync[1];
   rxState_t rxState;
   logic [CW-1:0] rxCnt;
   logic [BW-1:0] rxBit;
   logic [DATA_BITS-1:0] rxShift;
   logic rxParErr;
   logic rxSample;
   logic rxPush;
   assign rxSample = rxCnt == LAST;
   assign rxPush = rxState == RX_STOP && rxSample;
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         rxState <= RX_IDLE;
         rxCnt <= '0;
         rxBit <= '0;
         rxShift <= '0;
         rxParErr <= 1'b0;
      end else
         case (rxState)
            // the detection cycle counts as the first of the half-bit wait
            RX_IDLE:
               if (!rxS) begin
                  rxState <= RX_START;
                  rxCnt <= CW'(1);
                  rxBit <= '0;
                  rxParErr <= 1'b0;
               end
            RX_START:
               if (rxCnt == HALF) begin
                  rxCnt <= '0;
                  rxState <= rxS ? RX_IDLE : RX_DATA;
               end else rxCnt <= rxCnt + 1'b1;
            RX_DATA, RX_PARITY, RX_STOP:
               if (!rxSample) rxCnt <= rxCnt + 1'b1;
               else begin
                  rxCnt <= '0;
                  if (rxState == RX_DATA) begin
                     rxShift <= {rxS, rxShift[DATA_BITS-1:1]};
                     rxBit <= rxBit + 1'b1;
                     if (rxBit == BW'(DATA_BITS - 1)) rxState <= HAS_PAR ? RX_PARITY : RX_STOP;
                  end else if (rxState == RX_PARITY) begin
                     rxParErr <= rxS != (^rxShift ^ ODD);
                     rxState <= RX_STOP;
                  end else rxState <= rxS ? RX_IDLE : RX_WAIT_IDLE;
               end
            // a low stop bit may be a break: hold off until the line idles
            RX_WAIT_IDLE: if (rxS) rxState <= RX_IDLE;
            default: rxState <= RX_IDLE;
         endcase
   logic [FW-1:0] head;
   logic rxFull;
   logic rxEmpty;
   logic [AW:0] rxCount;
   logic rxOverrun;
   uart_rx_fifo #(.WIDTH(FW), .DEPTH(RX_FIFO_DEPTH)) fifo (
      .clk,
      .rst,
      .push(rxPush),
      .pop(bus.rx_ready),
      .wrData({rxParErr, ~rxS, rxShift}),
      .rdData(head),
      .full(rxFull),
      .empty(rxEmpty),
      .count(rxCount)
   );
   assign bus.rx_valid = rxCount != '0;
   assign {bus.rx_parity_err, bus.rx_frame_err, bus.rx_data} = head;
   always_ff @(posedge clk or posedge rst)
      if (rst) rxOverrun <= 1'b0;
      else rxOverrun <= rxPush && rxFull && !(bus.rx_ready && !rxEmpty);
   assign bus.rx_overrun = rxOverrun;
endmodule

// File: tb/tb_uart_core.sv
// tb_uart_core: scoreboard bench; dutA is 8N1, dutB is 8E2 with optional TX->RX loopback
module tb_uart_core;
   localparam int CPB = 16;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic rxA = 1'b1;
   logic txA;
   logic txB;
   logic rxB;
   logic rxDrv = 1'b1;
   logic loopB = 1'b0;
   int tests = 0;
   int fails = 0;
   int ovCount = 0;
   logic [9:0] q[$];
   logic [9:0] expWord;
   logic [9:0] gotWord;
   uart_if #(.DATA_BITS(8)) busA();
   uart_if #(.DATA_BITS(8)) busB();
   assign rxB = loopB ? txB : rxDrv;
   uart_core #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .RX_FIFO_DEPTH(4)) dutA (
      .clk(clk), .rst(rst), .bus(busA), .uart_rx(rxA), .uart_tx(txA)
   );
   uart_core #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(2), .STOP_BITS(2), .RX_FIFO_DEPTH(4)) dutB (
      .clk(clk), .rst(rst), .bus(busB), .uart_rx(rxB), .uart_tx(txB)
   );
   always #5 clk = ~clk;
   // scoreboard: every pop on dutB is checked against the queue front
   always begin
      @(negedge clk);
      #1;
      if (busB.rx_overrun) ovCount++;
      if (busB.rx_valid && busB.rx_ready) begin
         tests++;
         gotWord = {busB.rx_parity_err, busB.rx_frame_err, busB.rx_data};
         if (q.size() == 0) begin
            fails++;
            $display("FAIL rx_pop: got {perr,ferr,data}=%h, want no byte", gotWord);
         end else begin
            expWord = q.pop_front();
            if (gotWord !== expWord) begin
               fails++;
               $display("FAIL rx_pop: got {perr,ferr,data}=%h, want %h", gotWord, expWord);
            end
         end
      end
   end
   task automatic sendSerial(input logic [7:0] d, input bit badPar, input bit badStop, input int popAt);
      logic [11:0] bits;
      bits = {2'b11, ^d ^ badPar, d, 1'b0};
      if (badStop) bits[11:10] = 2'b00;
      for (int c = 0; c < 12 * CPB; c++) begin
         rxDrv = bits[c/CPB];
         if (popAt >= 0) busB.rx_ready = (c == popAt);
         @(negedge clk);
      end
   endtask
   task automatic waitDrain(input string name);
      int n;
      n = 0;
      while (q.size() != 0 && n < 2000) begin
         @(negedge clk);
         n++;
      end
      tests++;
      if (q.size() != 0) begin
         fails++;
         $display("FAIL %s_drain: %0d bytes outstanding, want 0", name, q.size());
         q.delete();
      end
   endtask
   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      tests += 4;
      if ({txA, busA.tx_ready, busA.rx_valid, busA.rx_overrun} !== 4'b1100) begin
         fails++;
         $display("FAIL reset_a_ctl: got %b, want 1100", {txA, busA.tx_ready, busA.rx_valid, busA.rx_overrun});
      end
      if ({busA.rx_parity_err, busA.rx_frame_err, busA.rx_data} !== 10'h0) begin
         fails++;
         $display("FAIL reset_a_data: got %h, want 000", {busA.rx_parity_err, busA.rx_frame_err, busA.rx_data});
      end
      if ({txB, busB.tx_ready, busB.rx_valid, busB.rx_overrun} !== 4'b1100) begin
         fails++;
         $display("FAIL reset_b_ctl: got %b, want 1100", {txB, busB.tx_ready, busB.rx_valid, busB.rx_overrun});
      end
      if ({busB.rx_parity_err, busB.rx_frame_err, busB.rx_data} !== 10'h0) begin
         fails++;
         $display("FAIL reset_b_data: got %h, want 000", {busB.rx_parity_err, busB.rx_frame_err, busB.rx_data});
      end
      rst = 1'b0;
      repeat (2) @(negedge clk);
   endtask
   task automatic test_tx_8n1();
      logic [9:0] frame;
      frame = {1'b1, 8'h55, 1'b0};
      busA.tx_data = 8'h55;
      busA.tx_valid = 1'b1;
      @(negedge clk);
      busA.tx_valid = 1'b0;
      busA.tx_data = 8'hFF;
      for (int i = 0; i < 10 * CPB; i++) begin
         tests++;
         if (txA !== frame[i/CPB] || busA.tx_ready !== 1'b0) begin
            fails++;
            $display("FAIL tx_8n1 cycle %0d: tx=%b ready=%b, want tx=%b ready=0", i, txA, busA.tx_ready, frame[i/CPB]);
         end
         @(negedge clk);
      end
      tests++;
      if (txA !== 1'b1 || busA.tx_ready !== 1'b1) begin
         fails++;
         $display("FAIL tx_8n1_end: tx=%b ready=%b, want 1 1", txA, busA.tx_ready);
      end
   endtask
   task automatic test_back_to_back();
      logic [7:0] d [3];
      int low;
      d = '{8'h00, 8'hFF, 8'hA3};
      busB.rx_ready = 1'b1;
      loopB = 1'b1;
      for (int i = 0; i < 3; i++) q.push_back({2'b00, d[i]});
      for (int i = 0; i < 3; i++) begin
         busB.tx_data = d[i];
         busB.tx_valid = 1'b1;
         @(negedge clk);
         busB.tx_valid = 1'b0;
         low = 0;
         while (!busB.tx_ready && low < 1000) begin
            low++;
            @(negedge clk);
         end
         tests++;
         if (low != 12 * CPB) begin
            fails++;
            $display("FAIL loop_frame_len %0d: got %0d cycles, want %0d", i, low, 12 * CPB);
         end
      end
      waitDrain("loopback");
      loopB = 1'b0;
   endtask
   task automatic test_errors();
      q.push_back({2'b10, 8'h3C});
      sendSerial(8'h3C, 1'b1, 1'b0, -1);
      waitDrain("parity");
      q.push_back({2'b01, 8'h5A});
      sendSerial(8'h5A, 1'b0, 1'b1, -1);
      rxDrv = 1'b0;
      repeat (3 * CPB) @(negedge clk);
      rxDrv = 1'b1;
      repeat (CPB) @(negedge clk);
      waitDrain("break");
      tests++;
      if (busB.rx_valid !== 1'b0) begin
         fails++;
         $display("FAIL break_quiet: rx_valid=%b, want 0", busB.rx_valid);
      end
      q.push_back({2'b00, 8'h81});
      sendSerial(8'h81, 1'b0, 1'b0, -1);
      waitDrain("after_break");
   endtask
   task automatic test_false_start();
      rxDrv = 1'b0;
      repeat (3) @(negedge clk);
      rxDrv = 1'b1;
      repeat (CPB) @(negedge clk);
      tests++;
      if (busB.rx_valid !== 1'b0) begin
         fails++;
         $display("FAIL false_start: rx_valid=%b, want 0", busB.rx_valid);
      end
      q.push_back({2'b00, 8'hC5});
      sendSerial(8'hC5, 1'b0, 1'b0, -1);
      waitDrain("false_start");
   endtask
   task automatic test_overrun();
      logic [7:0] d [5];
      d = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
      busB.rx_ready = 1'b0;
      ovCount = 0;
      for (int i = 0; i < 4; i++) q.push_back({2'b00, d[i]});
      for (int i = 0; i < 5; i++) sendSerial(d[i], 1'b0, 1'b0, -1);
      repeat (4) @(negedge clk);
      tests += 2;
      if (ovCount != 1) begin
         fails++;
         $display("FAIL overrun_pulses: got %0d, want 1", ovCount);
      end
      if ({busB.rx_valid, busB.rx_parity_err, busB.rx_frame_err, busB.rx_data} !== 11'h411) begin
         fails++;
         $display("FAIL overrun_head: got %h, want 411", {busB.rx_valid, busB.rx_parity_err, busB.rx_frame_err, busB.rx_data});
      end
      busB.rx_ready = 1'b1;
      waitDrain("overrun");
      repeat (2) @(negedge clk);
      tests++;
      if (busB.rx_valid !== 1'b0) begin
         fails++;
         $display("FAIL overrun_empty: rx_valid=%b, want 0", busB.rx_valid);
      end
      // second pass: a single-cycle pop lands on the fifth byte's push cycle
      busB.rx_ready = 1'b0;
      ovCount = 0;
      for (int i = 0; i < 5; i++) q.push_back({2'b00, ~d[i]});
      for (int i = 0; i < 4; i++) sendSerial(~d[i], 1'b0, 1'b0, -1);
      sendSerial(~d[4], 1'b0, 1'b0, 10 * CPB + CPB / 2 + 2);
      repeat (4) @(negedge clk);
      tests++;
      if (ovCount != 0) begin
         fails++;
         $display("FAIL pop_push_full: got %0d overrun pulses, want 0", ovCount);
      end
      busB.rx_ready = 1'b1;
      waitDrain("pop_push_full");
   endtask
   task automatic test_reset_mid();
      logic [11:0] bits;
      logic sawValid;
      bits = {2'b11, ^8'h96, 8'h96, 1'b0};
      busB.rx_ready = 1'b1;
      busB.tx_data = 8'hA1;
      busB.tx_valid = 1'b1;
      @(negedge clk);
      busB.tx_valid = 1'b0;
      for (int c = 0; c < 3 * CPB + CPB / 2; c++) begin
         rxDrv = bits[c/CPB];
         @(negedge clk);
      end
      tests++;
      if (txB !== 1'b0 || busB.tx_ready !== 1'b0) begin
         fails++;
         $display("FAIL mid_tx_busy: tx=%b ready=%b, want 0 0", txB, busB.tx_ready);
      end
      rst = 1'b1;
      #1;
      tests++;
      if (txB !== 1'b1 || busB.tx_ready !== 1'b1) begin
         fails++;
         $display("FAIL mid_reset: tx=%b ready=%b, want 1 1", txB, busB.tx_ready);
      end
      @(negedge clk);
      rxDrv = 1'b1;
      rst = 1'b0;
      sawValid = 1'b0;
      repeat (20 * CPB) begin
         @(negedge clk);
         if (busB.rx_valid) sawValid = 1'b1;
      end
      tests++;
      if (sawValid !== 1'b0) begin
         fails++;
         $display("FAIL mid_reset_rx: rx_valid seen=%b, want 0", sawValid);
      end
   endtask
   initial begin
      busA.tx_data = '0;
      busA.tx_valid = 1'b0;
      busA.rx_ready = 1'b0;
      busB.tx_data = '0;
      busB.tx_valid = 1'b0;
      busB.rx_ready = 1'b0;
      test_reset();
      test_tx_8n1();
      test_back_to_back();
      test_errors();
      test_false_start();
      test_overrun();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
